// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage program counter.
//   Sequences pc with stall holding, applies word-aligned redirects from decode, and
//   keeps a redirect that arrives while fetch is stalled until the stall clears.
// Ports:
//   i_clock              rising-edge clock
//   i_reset              synchronous active-high reset
//   i_stall              hazard-unit stall; pc holds while high
//   i_redirect_valid     decode presents a taken jump/branch target
//   i_redirect_address   target address from decode
//   o_pc                 registered fetch address
//   o_pc_plus_four       combinational o_pc + 4 (wraps modulo 2^32)
//   o_fetch_valid        IF/ID captures the instruction at o_pc this cycle
//   o_redirect_taken     one-cycle pulse: pc was loaded from a redirect on the last edge
//   o_misaligned         one-cycle pulse: the applied redirect had nonzero bits [1:0]
//   o_redirect_held      a redirect is pending inside the block
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_address,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus_four,
   output logic        o_fetch_valid,
   output logic        o_redirect_taken,
   output logic        o_misaligned,
   output logic        o_redirect_held
);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_pending;
   logic [31:0] w_pending_next;
   logic        r_redirect_taken;
   logic        w_redirect_taken_next;
   logic        r_misaligned;
   logic        w_misaligned_next;
   logic [31:0] w_target;

   // On release from HOLD a live redirect is newer than the pending one, so it wins.
   assign w_target = (r_state == StHold && !i_redirect_valid) ? r_pending : i_redirect_address;

   always_comb begin
      w_state_next          = r_state;
      w_pc_next             = r_pc;
      w_pending_next        = r_pending;
      w_redirect_taken_next = 1'b0;
      w_misaligned_next     = 1'b0;
      case (r_state)
         StBoot: begin
            w_state_next = StRun;
         end
         StRun: begin
            if (!i_stall) begin
               if (i_redirect_valid) begin
                  w_pc_next             = {w_target[31:2], 2'b00};
                  w_redirect_taken_next = 1'b1;
                  w_misaligned_next     = |w_target[1:0];
               end else begin
                  w_pc_next = r_pc + 32'd4;
               end
            end else if (i_redirect_valid) begin
               w_pending_next = i_redirect_address;
               w_state_next   = StHold;
            end
         end
         StHold: begin
            if (i_stall) begin
               if (i_redirect_valid) begin
                  w_pending_next = i_redirect_address;
               end
            end else begin
               w_pc_next             = {w_target[31:2], 2'b00};
               w_redirect_taken_next = 1'b1;
               w_misaligned_next     = |w_target[1:0];
               w_pending_next        = 32'd0;
               w_state_next          = StRun;
            end
         end
         default: begin
            w_state_next = StBoot;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state          <= StBoot;
         r_pc             <= RESET_PC;
         r_pending        <= 32'd0;
         r_redirect_taken <= 1'b0;
         r_misaligned     <= 1'b0;
      end else begin
         r_state          <= w_state_next;
         r_pc             <= w_pc_next;
         r_pending        <= w_pending_next;
         r_redirect_taken <= w_redirect_taken_next;
         r_misaligned     <= w_misaligned_next;
      end
   end

   assign o_pc             = r_pc;
   assign o_pc_plus_four   = r_pc + 32'd4;
   assign o_fetch_valid    = (r_state != StBoot) & ~i_stall & ~i_reset;
   assign o_redirect_taken = r_redirect_taken;
   assign o_misaligned     = r_misaligned;
   assign o_redirect_held  = (r_state == StHold);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table, a few hand sequences, then random stimulus
// checked against a behavioural model of the fetch PC.
module tb_fetch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stl;
   logic        rv;
   logic [31:0] ra;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fv;
   logic        taken;
   logic        mis;
   logic        held;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
      .i_clock            (clk),
      .i_reset            (rst),
      .i_stall            (stl),
      .i_redirect_valid   (rv),
      .i_redirect_address (ra),
      .o_pc               (pc),
      .o_pc_plus_four     (pc4),
      .o_fetch_valid      (fv),
      .o_redirect_taken   (taken),
      .o_misaligned       (mis),
      .o_redirect_held    (held)
   );

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc = RST_PC;
   bit          m_boot = 1'b1;
   bit          m_taken, m_mis;
   logic [31:0] m_pend_q[$];

   function automatic bit m_fv(bit r, bit s);
      return !m_boot && !s && !r;
   endfunction

   task automatic m_apply(logic [31:0] a);
      m_pc    = a & 32'hFFFF_FFFC;
      m_taken = 1'b1;
      m_mis   = (a % 4) != 0;
   endtask

   task automatic m_step(bit r, bit s, bit v, logic [31:0] a);
      m_taken = 1'b0;
      m_mis   = 1'b0;
      if (r) begin
         m_pc   = RST_PC;
         m_boot = 1'b1;
         m_pend_q.delete();
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_pend_q.size() != 0) begin
         if (s) begin
            if (v) m_pend_q.push_back(a);
         end else begin
            m_apply(v ? a : m_pend_q[$]);
            m_pend_q.delete();
         end
      end else if (!s) begin
         if (v) m_apply(a);
         else   m_pc = m_pc + 32'd4;
      end else if (v) begin
         m_pend_q.push_back(a);
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle, check fetch_valid before the edge and registered outputs after it.
   task automatic cyc(bit r, bit s, bit v, logic [31:0] a, string tag);
      rst = r; stl = s; rv = v; ra = a;
      #1;
      chk({tag, " fetch_valid"}, 32'(fv), 32'(m_fv(r, s)));
      @(posedge clk);
      m_step(r, s, v, a);
      #1;
      chk({tag, " pc"}, pc, m_pc);
      chk({tag, " pc_plus_four"}, pc4, m_pc + 32'd4);
      chk({tag, " redirect_taken"}, 32'(taken), 32'(m_taken));
      chk({tag, " misaligned"}, 32'(mis), 32'(m_mis));
      chk({tag, " redirect_held"}, 32'(held), 32'(m_pend_q.size() != 0));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          r, s, v;
      logic [31:0] a;
      bit          e_fv;
      logic [31:0] e_pc;
      bit          e_taken, e_mis, e_held;
   } vec_t;

   vec_t vq[$];

   task automatic add(bit r, bit s, bit v, logic [31:0] a, bit efv, logic [31:0] epc,
                      bit et, bit em, bit eh);
      vec_t x;
      x.r = r; x.s = s; x.v = v; x.a = a; x.e_fv = efv; x.e_pc = epc;
      x.e_taken = et; x.e_mis = em; x.e_held = eh;
      vq.push_back(x);
   endtask

   initial begin
      rst = 1'b1; stl = 1'b0; rv = 1'b0; ra = 32'd0;
      @(posedge clk);
      #1;

      //   r  s  v  addr           fv  pc            tk mis held
      add(1, 0, 0, 32'h0,         0, 32'h0040_0000, 0, 0, 0);
      add(0, 0, 0, 32'h0,         0, 32'h0040_0000, 0, 0, 0); // BOOT
      add(0, 0, 0, 32'h0,         1, 32'h0040_0004, 0, 0, 0);
      add(0, 0, 0, 32'h0,         1, 32'h0040_0008, 0, 0, 0);
      add(0, 0, 0, 32'h0,         1, 32'h0040_000C, 0, 0, 0);
      add(0, 0, 0, 32'h0,         1, 32'h0040_0010, 0, 0, 0);
      add(0, 0, 1, 32'h0040_0100, 1, 32'h0040_0100, 1, 0, 0); // delay slot fetched
      add(0, 0, 0, 32'h0,         1, 32'h0040_0104, 0, 0, 0);
      add(0, 1, 1, 32'h0040_1000, 0, 32'h0040_0104, 0, 0, 1);
      add(0, 1, 1, 32'h0040_2000, 0, 32'h0040_0104, 0, 0, 1);
      add(0, 1, 0, 32'h0,         0, 32'h0040_0104, 0, 0, 1);
      add(0, 0, 0, 32'h0,         1, 32'h0040_2000, 1, 0, 0); // latest pending wins
      add(0, 0, 0, 32'h0,         1, 32'h0040_2004, 0, 0, 0);
      add(0, 1, 1, 32'h0040_1000, 0, 32'h0040_2004, 0, 0, 1);
      add(0, 0, 1, 32'h0040_3000, 1, 32'h0040_3000, 1, 0, 0); // live input wins
      add(0, 0, 1, 32'h0040_0102, 1, 32'h0040_0100, 1, 1, 0); // misaligned
      add(0, 0, 0, 32'h0,         1, 32'h0040_0104, 0, 0, 0);
      add(0, 1, 1, 32'h0040_5000, 0, 32'h0040_0104, 0, 0, 1);
      add(1, 1, 0, 32'h0,         0, 32'h0040_0000, 0, 0, 0); // reset in HOLD
      add(0, 0, 0, 32'h0,         0, 32'h0040_0000, 0, 0, 0);
      add(0, 0, 0, 32'h0,         1, 32'h0040_0004, 0, 0, 0); // pending discarded
      add(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 0);
      add(0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 0, 0); // wrap
      add(0, 0, 0, 32'h0,         1, 32'h0000_0004, 0, 0, 0);
      add(1, 0, 0, 32'h0,         0, 32'h0040_0000, 0, 0, 0);
      add(0, 0, 1, 32'h1234_5678, 0, 32'h0040_0000, 0, 0, 0); // redirect in BOOT ignored
      add(0, 0, 0, 32'h0,         1, 32'h0040_0004, 0, 0, 0);

      foreach (vq[i]) begin
         rst = vq[i].r; stl = vq[i].s; rv = vq[i].v; ra = vq[i].a;
         #1;
         chk($sformatf("vec%0d fetch_valid", i), 32'(fv), 32'(vq[i].e_fv));
         @(posedge clk);
         m_step(vq[i].r, vq[i].s, vq[i].v, vq[i].a);
         #1;
         chk($sformatf("vec%0d pc", i), pc, vq[i].e_pc);
         chk($sformatf("vec%0d pc_plus_four", i), pc4, vq[i].e_pc + 32'd4);
         chk($sformatf("vec%0d redirect_taken", i), 32'(taken), 32'(vq[i].e_taken));
         chk($sformatf("vec%0d misaligned", i), 32'(mis), 32'(vq[i].e_mis));
         chk($sformatf("vec%0d redirect_held", i), 32'(held), 32'(vq[i].e_held));
      end

      // Hand sequence: long stall without redirect holds pc and never enters HOLD.
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, 32'h0, "stall_run");
      chk("stall_run pc frozen", pc, 32'h0040_0004);
      cyc(0, 0, 0, 32'h0, "stall_run_release");
      chk("stall_run next pc", pc, 32'h0040_0008);

      // Hand sequence: misaligned pending redirect released with no live input.
      cyc(0, 1, 1, 32'h0040_0203, "hold_mis");
      cyc(0, 1, 0, 32'h0, "hold_mis");
      cyc(0, 0, 0, 32'h0, "hold_mis_release");
      chk("hold_mis pc", pc, 32'h0040_0200);
      chk("hold_mis flag", 32'(mis), 32'd1);
      cyc(0, 0, 0, 32'h0, "hold_mis_after");
      chk("hold_mis flag clears", 32'(mis), 32'd0);

      // Random stimulus against the model.
      for (int k = 0; k < 600; k++) begin
         bit          r, s, v;
         logic [31:0] a;
         r = ($urandom_range(0, 49) == 0);
         s = ($urandom_range(0, 9) < 3);
         v = ($urandom_range(0, 9) < 3);
         a = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         cyc(r, s, v, a, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
